encrypt_key_scheduler: RTL

//  Front-end controller for the encrypt pipeline. Holds the key set and accepts one

---
 rtl/encrypt_key_scheduler.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/encrypt_key_scheduler.sv
// Front-end controller for the encrypt pipeline: key set, valid/ready character
// intake, one registered stage per character and periodic key rotation.
module encrypt_key_scheduler #(
  parameter int CNT_W  = 16,
  parameter bit ROT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [7:0]       cfg_k1,
  input  logic [7:0]       cfg_k2,
  input  logic [7:0]       cfg_k3,
  input  logic [2:0]       cfg_rot_freq,
  input  logic             cfg_mode,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             en,
  output logic [7:0]       din,
  output logic [7:0]       k1,
  output logic [7:0]       k2,
  output logic [7:0]       k3,
  output logic [2:0]       rot_freq,
  output logic             mode,
  output logic             shift_en,
  output logic [3:0]       shift_amt,
  output logic             busy,
  output logic [CNT_W-1:0] proc_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;
  localparam logic [1:0] ROTATE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [7:0]       key1_q, key1_d;
  logic [7:0]       key2_q, key2_d;
  logic [7:0]       key3_q, key3_d;
  logic [2:0]       rot_cnt_q, rot_cnt_d;
  logic [2:0]       rot_freq_q, rot_freq_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] proc_cnt_q, proc_cnt_d;
  logic             en_q, en_d;
  logic [7:0]       din_q, din_d;
  logic [7:0]       k1_q, k1_d;
  logic [7:0]       k2_q, k2_d;
  logic [7:0]       k3_q, k3_d;
  logic             shift_en_q, shift_en_d;
  logic [3:0]       shift_amt_q, shift_amt_d;
  logic             accept;

  assign in_ready  = (state_q == RUN) & ~cfg_load;
  assign accept    = in_valid & in_ready;
  assign busy      = (state_q != IDLE);
  assign en        = en_q;
  assign din       = din_q;
  assign k1        = k1_q;
  assign k2        = k2_q;
  assign k3        = k3_q;
  assign rot_freq  = rot_freq_q;
  assign mode      = mode_q;
  assign shift_en  = shift_en_q;
  assign shift_amt = shift_amt_q;
  assign proc_cnt  = proc_cnt_q;

  always_comb begin
    state_d     = state_q;
    key1_d      = key1_q;
    key2_d      = key2_q;
    key3_d      = key3_q;
    rot_cnt_d   = rot_cnt_q;
    rot_freq_d  = rot_freq_q;
    mode_d      = mode_q;
    proc_cnt_d  = proc_cnt_q;
    en_d        = 1'b0;
    din_d       = din_q;
    k1_d        = k1_q;
    k2_d        = k2_q;
    k3_d        = k3_q;
    shift_en_d  = shift_en_q;
    shift_amt_d = shift_amt_q;
    if (cfg_load) begin
      state_d    = LOAD;
      key1_d     = cfg_k1;
      key2_d     = cfg_k2;
      key3_d     = cfg_k3;
      rot_freq_d = cfg_rot_freq;
      mode_d     = cfg_mode;
      rot_cnt_d  = 3'd0;
      proc_cnt_d = '0;
    end else begin
      case (state_q)
        LOAD: state_d = RUN;
        RUN: begin
          if (accept) begin
            en_d        = 1'b1;
            din_d       = in_data;
            k1_d        = key1_q;
            k2_d        = key2_q;
            k3_d        = key3_q;
            shift_amt_d = key1_q[3:0];
            shift_en_d  = (key1_q[3:0] != 4'd0);
            if (!(&proc_cnt_q))
              proc_cnt_d = proc_cnt_q + 1'b1;
            if (rot_cnt_q == rot_freq_q) begin
              rot_cnt_d = 3'd0;
              if (ROT_EN)
                state_d = ROTATE;
            end else begin
              rot_cnt_d = rot_cnt_q + 3'd1;
            end
          end
        end
        ROTATE: begin
          // k3 receives the old k1 rotated left by one
          key1_d  = key2_q;
          key2_d  = key3_q;
          key3_d  = {key1_q[6:0], key1_q[7]};
          state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      key1_q      <= '0;
      key2_q      <= '0;
      key3_q      <= '0;
      rot_cnt_q   <= '0;
      rot_freq_q  <= '0;
      mode_q      <= 1'b0;
      proc_cnt_q  <= '0;
      en_q        <= 1'b0;
      din_q       <= '0;
      k1_q        <= '0;
      k2_q        <= '0;
      k3_q        <= '0;
      shift_en_q  <= 1'b0;
      shift_amt_q <= '0;
    end else begin
      state_q     <= state_d;
      key1_q      <= key1_d;
      key2_q      <= key2_d;
      key3_q      <= key3_d;
      rot_cnt_q   <= rot_cnt_d;
      rot_freq_q  <= rot_freq_d;
      mode_q      <= mode_d;
      proc_cnt_q  <= proc_cnt_d;
      en_q        <= en_d;
      din_q       <= din_d;
      k1_q        <= k1_d;
      k2_q        <= k2_d;
      k3_q        <= k3_d;
      shift_en_q  <= shift_en_d;
      shift_amt_q <= shift_amt_d;
    end
  end

endmodule
